tour_cmd_sched: RTL and testbench

- Command scheduler sitting between a host-side command source (bench task or script ROM) and the RemoteComm BLE/UART master.
- Buffers a queue of 16-bit Knight commands (calibrate, move with direction/count/fanfare).
- Issues the commands one at a time through RemoteComm's send_cmd/cmd_sent handshake, waits for the DUT's completion byte, checks it, then advances.
- Stops on a wrong response, a response timeout, or an abort.

---
 rtl/tour_cmd_sched_if.sv | 22 ++
 rtl/tour_cmd_sched.sv | 200 ++++++++++++++++++++
 tb/tb_tour_cmd_sched.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tour_cmd_sched_if.sv
// Link between the command scheduler and the RemoteComm BLE/UART master.
// The scheduler is the master: it drives the command word and both pulses.
interface tour_cmd_sched_if;
    logic [15:0] cmd;
    logic        send_cmd;
    logic        cmd_sent;
    logic        resp_rdy;
    logic [7:0]  resp;
    logic        clr_rx_rdy;

    // send_cmd and clr_rx_rdy are single-cycle pulses; cmd_sent and resp_rdy
    // are levels that the scheduler samples only in the states waiting for them.
    modport master (
        output cmd, send_cmd, clr_rx_rdy,
        input  cmd_sent, resp_rdy, resp
    );

    modport slave (
        input  cmd, send_cmd, clr_rx_rdy,
        output cmd_sent, resp_rdy, resp
    );
endinterface

// File: rtl/tour_cmd_sched.sv
// Queues 16-bit Knight commands and issues them one at a time to RemoteComm,
// checking each completion byte and stopping on a bad byte, timeout or abort.
module tour_cmd_sched #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned TMO_CYC  = 10000000,
    parameter logic [7:0]  ACK_BYTE = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [15:0]            i_wr_data,
    input  logic                   i_start,
    input  logic                   i_abort,
    tour_cmd_sched_if.master       rc,
    output logic                   o_full,
    output logic                   o_empty,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_err,
    output logic [1:0]             o_err_code,
    output logic [7:0]             o_n_ok,
    output logic [2:0]             o_state
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TMO_CYC + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [TW-1:0] TMO_VAL  = TW'(TMO_CYC);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_SEND      = 3'd2,
        S_WAIT_SENT = 3'd3,
        S_WAIT_RESP = 3'd4,
        S_CHECK     = 3'd5,
        S_DONE      = 3'd6,
        S_ERR       = 3'd7
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [15:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [15:0]     r_cmd;
    logic [7:0]      r_resp;
    logic [TW-1:0]   r_timer;
    logic            r_done;
    logic            r_err;
    logic [1:0]      r_err_code;
    logic [7:0]      r_n_ok;

    logic            w_full;
    logic            w_empty;
    logic            w_wr;
    logic            w_pop;
    logic            w_ovf;
    logic            w_send;
    logic            w_clr;
    logic            w_restart;
    logic            w_ack;
    logic            w_fail;
    logic [1:0]      w_fail_code;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_wr    = i_push && !w_full && !i_abort;
    assign w_ovf   = i_push &&  w_full && !i_abort;
    assign w_pop   = (r_state == S_LOAD) && !i_abort;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= i_wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_abort) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + AW'(1);
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // DONE and ERR accept a new start exactly like IDLE does.
    always_comb begin
        w_next      = r_state;
        w_send      = 1'b0;
        w_clr       = 1'b0;
        w_restart   = 1'b0;
        w_ack       = 1'b0;
        w_fail      = 1'b0;
        w_fail_code = 2'b00;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (i_start) begin
                    w_restart = 1'b1;
                    w_next    = w_empty ? S_DONE : S_LOAD;
                end
            end
            S_LOAD:      w_next = S_SEND;
            S_SEND: begin
                w_send = 1'b1;
                w_next = S_WAIT_SENT;
            end
            S_WAIT_SENT: if (rc.cmd_sent) w_next = S_WAIT_RESP;
            S_WAIT_RESP: begin
                if (rc.resp_rdy) begin
                    w_next = S_CHECK;
                end else if (r_timer == TMO_VAL) begin
                    w_next      = S_ERR;
                    w_fail      = 1'b1;
                    w_fail_code = 2'b10;
                end
            end
            S_CHECK: begin
                w_clr = 1'b1;
                if (r_resp == ACK_BYTE) begin
                    w_ack  = 1'b1;
                    w_next = w_empty ? S_DONE : S_LOAD;
                end else begin
                    w_next      = S_ERR;
                    w_fail      = 1'b1;
                    w_fail_code = 2'b01;
                end
            end
            default:     w_next = S_IDLE;
        endcase
        if (i_abort) begin
            w_next    = S_IDLE;
            w_send    = 1'b0;
            w_clr     = 1'b0;
            w_restart = 1'b0;
            w_ack     = 1'b0;
            w_fail    = 1'b0;
        end
    end

    // Overflow is written last so it wins over any other error in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cmd      <= '0;
            r_resp     <= '0;
            r_timer    <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
            r_n_ok     <= '0;
        end else begin
            r_state <= w_next;
            if (w_pop) r_cmd <= r_mem[r_rptr];
            if (r_state == S_WAIT_SENT)      r_timer <= '0;
            else if (r_state == S_WAIT_RESP) r_timer <= r_timer + TW'(1);
            if (r_state == S_WAIT_RESP && rc.resp_rdy) r_resp <= rc.resp;
            if (w_restart) begin
                r_done     <= 1'b0;
                r_err      <= 1'b0;
                r_err_code <= 2'b00;
                r_n_ok     <= '0;
            end
            if (w_ack && r_n_ok != 8'hFF) r_n_ok <= r_n_ok + 8'd1;
            if (w_next == S_DONE) r_done <= 1'b1;
            if (w_fail) begin
                r_err      <= 1'b1;
                r_err_code <= w_fail_code;
            end
            if (w_ovf) begin
                r_err      <= 1'b1;
                r_err_code <= 2'b11;
            end
        end
    end

    assign rc.cmd        = r_cmd;
    assign rc.send_cmd   = w_send;
    assign rc.clr_rx_rdy = w_clr;
    assign o_full        = w_full;
    assign o_empty       = w_empty;
    assign o_busy        = !(r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
    assign o_done        = r_done;
    assign o_err         = r_err;
    assign o_err_code    = r_err_code;
    assign o_n_ok        = r_n_ok;
    assign o_state       = r_state;

endmodule

// File: tb/tb_tour_cmd_sched.sv
// Bench for tour_cmd_sched: a table of command sequences with a RemoteComm
// responder, plus hand-written timeout, overflow, abort and reset sequences.
module tb_tour_cmd_sched;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT_RESP = 3'd4;
  localparam logic [2:0] ST_ERR = 3'd7;
  localparam int NV = 6;

  logic clk;
  logic rst_n;
  logic i_push;
  logic [15:0] i_wr_data;
  logic i_start;
  logic i_abort;
  logic o_full;
  logic o_empty;
  logic o_busy;
  logic o_done;
  logic o_err;
  logic [1:0] o_err_code;
  logic [7:0] o_n_ok;
  logic [2:0] o_state;

  tour_cmd_sched_if rc ();

  tour_cmd_sched #(.DEPTH(8), .TMO_CYC(100), .ACK_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .i_push(i_push), .i_wr_data(i_wr_data),
    .i_start(i_start), .i_abort(i_abort), .rc(rc),
    .o_full(o_full), .o_empty(o_empty), .o_busy(o_busy), .o_done(o_done),
    .o_err(o_err), .o_err_code(o_err_code), .o_n_ok(o_n_ok), .o_state(o_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    int n;
    logic [3:0][15:0] w;
    logic [3:0][7:0] r;
    int served;
    int rdly;
    logic [7:0] n_ok;
    logic done;
    logic err;
    logic [1:0] code;
    logic empty;
  } vec_t;

  vec_t vec[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // driver tasks: entered just after a falling edge, leave just after one
  task automatic push_word(input logic [15:0] w);
    if (exp_q.size() < 8) exp_q.push_back(w);
    i_push = 1'b1;
    i_wr_data = w;
    @(negedge clk);
    i_push = 1'b0;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic do_abort();
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_send(output bit seen);
    int t;
    logic [15:0] e;
    seen = 1'b0;
    t = 0;
    while (t < 20 && !seen) begin
      @(negedge clk);
      if (rc.send_cmd) seen = 1'b1;
      t++;
    end
    check("send_seen", 32'(seen), 32'd1);
    if (seen) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      check("cmd_order", 32'(rc.cmd), 32'(e));
    end
  endtask

  task automatic send_done();
    @(negedge clk);
    check("send_width", 32'(rc.send_cmd), 32'd0);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    rc.cmd_sent = 1'b1;
    @(negedge clk);
    rc.cmd_sent = 1'b0;
  endtask

  task automatic serve(input logic [7:0] rsp, input int rdly);
    bit seen;
    wait_send(seen);
    if (seen) begin
      send_done();
      repeat (rdly) @(negedge clk);
      rc.resp = rsp;
      rc.resp_rdy = 1'b1;
      @(negedge clk);
      check("clr_rx_rdy", 32'(rc.clr_rx_rdy), 32'd1);
      rc.resp_rdy = 1'b0;
      rc.resp = 8'($urandom);
      @(negedge clk);
      check("clr_width", 32'(rc.clr_rx_rdy), 32'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 32'(o_state), 32'(ST_IDLE));
    check({tag, "_cmd"}, 32'(rc.cmd), 32'd0);
    check({tag, "_send"}, 32'(rc.send_cmd), 32'd0);
    check({tag, "_clr"}, 32'(rc.clr_rx_rdy), 32'd0);
    check({tag, "_done"}, 32'(o_done), 32'd0);
    check({tag, "_err"}, 32'(o_err), 32'd0);
    check({tag, "_code"}, 32'(o_err_code), 32'd0);
    check({tag, "_n_ok"}, 32'(o_n_ok), 32'd0);
    check({tag, "_full"}, 32'(o_full), 32'd0);
    check({tag, "_empty"}, 32'(o_empty), 32'd1);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    bit seen;
    int extra;
    int clr_cnt;

    vec[0] = '{n:1, w:{16'h0, 16'h0, 16'h0, 16'h2000}, r:{8'h0, 8'h0, 8'h0, 8'hA5},
               served:1, rdly:-1, n_ok:8'd1, done:1'b1, err:1'b0, code:2'b00, empty:1'b1};
    vec[1] = '{n:3, w:{16'h0, 16'h4102, 16'h4011, 16'h2000}, r:{8'h0, 8'hA5, 8'hA5, 8'hA5},
               served:3, rdly:-1, n_ok:8'd3, done:1'b1, err:1'b0, code:2'b00, empty:1'b1};
    vec[2] = '{n:1, w:{16'h0, 16'h0, 16'h0, 16'h4011}, r:{8'h0, 8'h0, 8'h0, 8'h5A},
               served:1, rdly:-1, n_ok:8'd0, done:1'b0, err:1'b1, code:2'b01, empty:1'b1};
    vec[3] = '{n:3, w:{16'h0, 16'h4102, 16'h4011, 16'h1234}, r:{8'h0, 8'h0, 8'h00, 8'hA5},
               served:2, rdly:-1, n_ok:8'd1, done:1'b0, err:1'b1, code:2'b01, empty:1'b0};
    vec[4] = '{n:2, w:{16'h0, 16'h0, 16'h4021, 16'h4130}, r:{8'h0, 8'h0, 8'hA5, 8'hA5},
               served:2, rdly:100, n_ok:8'd2, done:1'b1, err:1'b0, code:2'b00, empty:1'b1};
    vec[5] = '{n:0, w:{16'h0, 16'h0, 16'h0, 16'h0}, r:{8'h0, 8'h0, 8'h0, 8'h0},
               served:0, rdly:-1, n_ok:8'd0, done:1'b1, err:1'b0, code:2'b00, empty:1'b1};

    rst_n = 1'b0;
    i_push = 1'b0;
    i_wr_data = '0;
    i_start = 1'b0;
    i_abort = 1'b0;
    rc.cmd_sent = 1'b0;
    rc.resp_rdy = 1'b0;
    rc.resp = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < NV; v++) begin
      do_abort();
      for (int i = 0; i < vec[v].n; i++) push_word(vec[v].w[i]);
      pulse_start();
      for (int i = 0; i < vec[v].served; i++)
        serve(vec[v].r[i], (vec[v].rdly < 0) ? int'($urandom_range(0, 5)) : vec[v].rdly);
      extra = 0;
      repeat (10) begin
        @(negedge clk);
        if (rc.send_cmd) extra++;
      end
      check($sformatf("v%0d_extra_send", v), 32'(extra), 32'd0);
      check($sformatf("v%0d_done", v), 32'(o_done), 32'(vec[v].done));
      check($sformatf("v%0d_err", v), 32'(o_err), 32'(vec[v].err));
      check($sformatf("v%0d_code", v), 32'(o_err_code), 32'(vec[v].code));
      check($sformatf("v%0d_n_ok", v), 32'(o_n_ok), 32'(vec[v].n_ok));
      check($sformatf("v%0d_empty", v), 32'(o_empty), 32'(vec[v].empty));
      check($sformatf("v%0d_busy", v), 32'(o_busy), 32'd0);
    end

    // overflow: ninth push dropped, flag raised, start drains the eight kept
    do_abort();
    for (int i = 0; i < 9; i++) begin
      push_word(16'h4000 + 16'(i));
      if (i == 7) begin
        check("ovf_full8", 32'(o_full), 32'd1);
        check("ovf_err8", 32'(o_err), 32'd0);
      end
    end
    check("ovf_err", 32'(o_err), 32'd1);
    check("ovf_code", 32'(o_err_code), 32'd3);
    check("ovf_full9", 32'(o_full), 32'd1);
    pulse_start();
    for (int i = 0; i < 8; i++) serve(8'hA5, int'($urandom_range(0, 3)));
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (rc.send_cmd) extra++;
    end
    check("ovf_extra_send", 32'(extra), 32'd0);
    check("ovf_n_ok", 32'(o_n_ok), 32'd8);
    check("ovf_done", 32'(o_done), 32'd1);
    check("ovf_empty", 32'(o_empty), 32'd1);

    // timeout: decision on the cycle the timer reaches 100
    do_abort();
    push_word(16'h4011);
    pulse_start();
    wait_send(seen);
    send_done();
    check("tmo_entry", 32'(o_state), 32'(ST_WAIT_RESP));
    repeat (100) @(negedge clk);
    check("tmo_c100_state", 32'(o_state), 32'(ST_WAIT_RESP));
    check("tmo_c100_err", 32'(o_err), 32'd0);
    @(negedge clk);
    check("tmo_state", 32'(o_state), 32'(ST_ERR));
    check("tmo_err", 32'(o_err), 32'd1);
    check("tmo_code", 32'(o_err_code), 32'd2);
    check("tmo_n_ok", 32'(o_n_ok), 32'd0);
    check("tmo_busy", 32'(o_busy), 32'd0);

    // abort during WAIT_RESP of the second command, with a push in the same cycle
    do_abort();
    push_word(16'h2000);
    push_word(16'h4011);
    push_word(16'h4102);
    pulse_start();
    serve(8'hA5, 1);
    wait_send(seen);
    send_done();
    repeat (3) @(negedge clk);
    i_abort = 1'b1;
    i_push = 1'b1;
    i_wr_data = 16'hBEEF;
    @(negedge clk);
    i_abort = 1'b0;
    i_push = 1'b0;
    check("abort_state", 32'(o_state), 32'(ST_IDLE));
    check("abort_empty", 32'(o_empty), 32'd1);
    check("abort_n_ok", 32'(o_n_ok), 32'd1);
    check("abort_busy", 32'(o_busy), 32'd0);
    clr_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (rc.clr_rx_rdy) clr_cnt++;
    end
    check("abort_no_clr", 32'(clr_cnt), 32'd0);
    exp_q.delete();

    // abort in CHECK suppresses clr_rx_rdy and the n_ok increment
    push_word(16'h4123);
    pulse_start();
    wait_send(seen);
    send_done();
    rc.resp = 8'hA5;
    rc.resp_rdy = 1'b1;
    @(negedge clk);
    rc.resp_rdy = 1'b0;
    i_abort = 1'b1;
    #1;
    check("abort_chk_clr", 32'(rc.clr_rx_rdy), 32'd0);
    @(negedge clk);
    i_abort = 1'b0;
    check("abort_chk_n_ok", 32'(o_n_ok), 32'd0);
    check("abort_chk_state", 32'(o_state), 32'(ST_IDLE));
    exp_q.delete();

    // asynchronous reset mid-sequence
    push_word(16'h2000);
    push_word(16'h4011);
    pulse_start();
    serve(8'hA5, 0);
    wait_send(seen);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
